// File: rtl/fifo_rd_pkg.sv
// Shared types and the byte-lane helper for the FIFO word reader.
// Word, byte and lane widths live here so the reader and any bench agree.
package fifo_rd_pkg;

    typedef enum logic {IDLE, SEND} state_t;

    localparam int DATA_W    = 32;
    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = DATA_W / BYTE_W;

    typedef logic [DATA_W-1:0] word_t;

    // Byte number idx of the word, counted from the top lane when msb_first is set.
    function automatic logic [BYTE_W-1:0] select_byte(input word_t w,
                                                      input logic [1:0] idx,
                                                      input logic msb_first);
        logic [1:0] lane;
        lane = msb_first ? (2'(NUM_BYTES - 1) - idx) : idx;
        case (lane)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

endpackage

// File: rtl/fifo_word_reader.sv
// Pops 32-bit words from a combinational-read FIFO and streams them out as bytes.
// Optional build macro FIFO_RD_STATS_EN adds a 16-bit pop counter output word_count.
module fifo_word_reader
    import fifo_rd_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_data,
    output logic        fifo_rd,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [15:0] word_count
`endif
);

    state_t      state_q;
    word_t       word_q;
    logic [1:0]  idx_q;

    logic        accept;
    logic        last_accept;
    logic        pop;

    // Byte stream handshake: a byte transfers on a rising edge where
    // byte_valid && byte_ready; while valid is high and ready is low,
    // byte_data and byte_valid hold their values unchanged.
    assign accept      = (state_q == SEND) && byte_ready;
    assign last_accept = accept && (idx_q == 2'd3);

    // Popping again on the last-byte accept lets words stream with no bubble.
    assign pop = reset_n && enable && !fifo_empty &&
                 ((state_q == IDLE) || last_accept);

    assign fifo_rd = pop;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= 2'd0;
        end else if (pop) begin
            state_q <= SEND;
            word_q  <= fifo_data;
            idx_q   <= 2'd0;
        end else if (last_accept) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
        end else if (accept) begin
            idx_q   <= idx_q + 2'd1;
        end
    end

    assign byte_valid = (state_q == SEND);
    assign busy       = (state_q == SEND);
    assign byte_data  = byte_valid ? select_byte(word_q, idx_q, MSB_FIRST) : 8'h00;

`ifdef FIFO_RD_STATS_EN
    logic [15:0] word_count_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            word_count_q <= 16'h0000;
        end else if (pop) begin
            word_count_q <= word_count_q + 16'h0001;
        end
    end

    assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_fifo_word_reader.sv
// Directed bench for fifo_word_reader: table-driven single words plus hand sequences
// for backpressure, back-to-back streaming, enable drop and reset mid-word.
module tb_fifo_word_reader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = 32'h0;
    logic        fifo_rd;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready = 1'b1;
    logic        busy;

    logic        rd_lsb;
    logic [7:0]  byte_data_lsb;
    logic        byte_valid_lsb;
    logic        busy_lsb;
`ifdef FIFO_RD_STATS_EN
    logic [15:0] word_count;
    logic [15:0] word_count_lsb;
`endif

    always #5 clock = ~clock;

    fifo_word_reader #(.MSB_FIRST(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy)
`ifdef FIFO_RD_STATS_EN
        , .word_count(word_count)
`endif
    );

    fifo_word_reader #(.MSB_FIRST(1'b0)) dut_lsb (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(rd_lsb),
        .byte_data(byte_data_lsb), .byte_valid(byte_valid_lsb), .byte_ready(byte_ready),
        .busy(busy_lsb)
`ifdef FIFO_RD_STATS_EN
        , .word_count(word_count_lsb)
`endif
    );

    // FIFO model and scoreboard
    logic [31:0] fq[$];
    logic [7:0]  exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Values captured just before the rising edge of the last cycle
    logic       r_rd, r_valid, r_busy;
    logic [7:0] r_data, r_data_lsb;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  msb[4];
        logic [7:0]  lsb[4];
    } vec_t;

    typedef struct {
        logic       rdy;
        logic [7:0] exp_byte;
    } bp_t;

    typedef struct {
        logic       rd;
        logic       valid;
        logic [7:0] exp_byte;
    } b2b_t;

    vec_t vecs[4];
    bp_t  bps[8];
    b2b_t b2b[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic update_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() == 0) ? 32'hDEAD_BEEF : fq[0];
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic cycle();
        logic [7:0] e;
        #1;
        r_rd       = fifo_rd;
        r_valid    = byte_valid;
        r_busy     = busy;
        r_data     = byte_data;
        r_data_lsb = byte_data_lsb;
        if (fifo_rd && fifo_empty) check("rd_while_empty", 1, 0);
        if (byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", {24'h0, byte_data}, 32'h0000_0100);
            end else begin
                e = exp_q.pop_front();
                check("sb_byte", {24'h0, byte_data}, {24'h0, e});
            end
        end
        @(posedge clock);
        #1;
        if (r_rd && fq.size() > 0) void'(fq.pop_front());
        update_fifo();
        @(negedge clock);
    endtask

    initial begin
        vecs[0] = '{32'hA1B2C3D4, '{8'hA1, 8'hB2, 8'hC3, 8'hD4}, '{8'hD4, 8'hC3, 8'hB2, 8'hA1}};
        vecs[1] = '{32'h0000_0000, '{8'h00, 8'h00, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[2] = '{32'hFFFF_FFFF, '{8'hFF, 8'hFF, 8'hFF, 8'hFF}, '{8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        vecs[3] = '{32'h0102_80FE, '{8'h01, 8'h02, 8'h80, 8'hFE}, '{8'hFE, 8'h80, 8'h02, 8'h01}};

        bps[0] = '{1'b0, 8'hA1}; bps[1] = '{1'b1, 8'hA1};
        bps[2] = '{1'b0, 8'hB2}; bps[3] = '{1'b0, 8'hB2};
        bps[4] = '{1'b1, 8'hB2}; bps[5] = '{1'b1, 8'hC3};
        bps[6] = '{1'b0, 8'hD4}; bps[7] = '{1'b1, 8'hD4};

        b2b[0] = '{1'b1, 1'b0, 8'h00}; b2b[1] = '{1'b0, 1'b1, 8'h11};
        b2b[2] = '{1'b0, 1'b1, 8'h22}; b2b[3] = '{1'b0, 1'b1, 8'h33};
        b2b[4] = '{1'b1, 1'b1, 8'h44}; b2b[5] = '{1'b0, 1'b1, 8'h55};
        b2b[6] = '{1'b0, 1'b1, 8'h66}; b2b[7] = '{1'b0, 1'b1, 8'h77};
        b2b[8] = '{1'b0, 1'b1, 8'h88}; b2b[9] = '{1'b0, 1'b0, 8'h00};

        // Reset with a non-empty FIFO and enable high: nothing may be popped
        fq.push_back(32'hCAFE_F00D);
        update_fifo();
        enable  = 1'b1;
        reset_n = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("reset_fifo_rd", r_rd, 0);
            check("reset_byte_valid", r_valid, 0);
            check("reset_busy", r_busy, 0);
        end
        check("reset_byte_data", r_data, 8'h00);
        check("reset_no_pop", fq.size(), 1);
`ifdef FIFO_RD_STATS_EN
        check("reset_word_count", word_count, 16'h0000);
`endif
        enable  = 1'b0;
        reset_n = 1'b1;
        cycle();
        check("disabled_fifo_rd", r_rd, 0);
        check("disabled_busy", r_busy, 0);
        fq.delete();
        update_fifo();

        // Single words, both byte orders
        enable     = 1'b1;
        byte_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            fq.push_back(vecs[v].word);
            update_fifo();
            for (int i = 0; i < 4; i++) exp_q.push_back(vecs[v].msb[i]);
            cycle();
            check("single_pop", r_rd, 1);
            check("single_pop_valid", r_valid, 0);
            for (int i = 0; i < 4; i++) begin
                cycle();
                check("single_valid", r_valid, 1);
                check("single_msb_byte", r_data, vecs[v].msb[i]);
                check("single_lsb_byte", r_data_lsb, vecs[v].lsb[i]);
                check("single_no_pop", r_rd, 0);
            end
            cycle();
            check("single_idle_valid", r_valid, 0);
            check("single_idle_busy", r_busy, 0);
            check("single_sb_drained", exp_q.size(), 0);
        end

        // Backpressure on 0xA1B2C3D4
        fq.push_back(32'hA1B2C3D4);
        update_fifo();
        exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
        exp_q.push_back(8'hC3); exp_q.push_back(8'hD4);
        cycle();
        check("bp_pop", r_rd, 1);
        for (int i = 0; i < 8; i++) begin
            byte_ready = bps[i].rdy;
            cycle();
            check("bp_valid", r_valid, 1);
            check("bp_byte", r_data, bps[i].exp_byte);
            check("bp_no_pop", r_rd, 0);
        end
        byte_ready = 1'b1;
        cycle();
        check("bp_idle", r_valid, 0);
        check("bp_sb_drained", exp_q.size(), 0);

        // Back-to-back words with no bubble
        fq.push_back(32'h1122_3344);
        fq.push_back(32'h5566_7788);
        update_fifo();
        for (int i = 1; i < 9; i++) exp_q.push_back(b2b[i].exp_byte);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("b2b_rd", r_rd, b2b[i].rd);
            check("b2b_valid", r_valid, b2b[i].valid);
            if (b2b[i].valid) check("b2b_byte", r_data, b2b[i].exp_byte);
        end
        check("b2b_sb_drained", exp_q.size(), 0);

        // Enable drops after byte 0x22: word finishes, no further pop
        fq.push_back(32'h1122_3344);
        fq.push_back(32'h5566_7788);
        update_fifo();
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        cycle();
        check("en_pop", r_rd, 1);
        cycle();
        cycle();
        check("en_byte_22", r_data, 8'h22);
        enable = 1'b0;
        cycle();
        check("en_byte_33", r_data, 8'h33);
        cycle();
        check("en_byte_44", r_data, 8'h44);
        check("en_no_pop_last", r_rd, 0);
        cycle();
        check("en_idle_valid", r_valid, 0);
        check("en_idle_busy", r_busy, 0);
        check("en_idle_no_pop", r_rd, 0);
        check("en_fifo_left", fq.size(), 1);
        check("en_sb_drained", exp_q.size(), 0);
        fq.delete();
        update_fifo();

        // Fresh reset, then three streamed words
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        enable  = 1'b1;
        fq.push_back(32'h0000_0001);
        fq.push_back(32'h0000_0002);
        fq.push_back(32'h0000_0003);
        update_fifo();
        for (int w = 1; w <= 3; w++) begin
            exp_q.push_back(8'h00); exp_q.push_back(8'h00);
            exp_q.push_back(8'h00); exp_q.push_back(w[7:0]);
        end
        for (int i = 0; i < 14; i++) cycle();
        check("three_sb_drained", exp_q.size(), 0);
        check("three_fifo_empty", fq.size(), 0);
`ifdef FIFO_RD_STATS_EN
        check("stats_three_words", word_count, 16'd3);
`endif

        // Reset during the second byte: partial word dropped, not re-popped
        fq.push_back(32'hA1B2C3D4);
        fq.push_back(32'h0BAD_F00D);
        update_fifo();
        exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
        cycle();
        check("rst_mid_pop", r_rd, 1);
        cycle();
        reset_n = 1'b0;
        enable  = 1'b0;
        cycle();
        check("rst_mid_byte2", r_data, 8'hB2);
        reset_n = 1'b1;
        #1;
        check("rst_mid_valid_after", byte_valid, 0);
        check("rst_mid_busy_after", busy, 0);
`ifdef FIFO_RD_STATS_EN
        check("stats_after_reset", word_count, 16'd0);
`endif
        cycle();
        check("rst_mid_no_repop", r_rd, 0);
        check("rst_mid_fifo_left", fq.size(), 1);
        enable = 1'b1;
        exp_q.push_back(8'h0B); exp_q.push_back(8'hAD);
        exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
        cycle();
        check("rst_mid_next_pop", r_rd, 1);
        cycle();
        check("rst_mid_next_first", r_data, 8'h0B);
        for (int i = 0; i < 4; i++) cycle();
        check("rst_mid_sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
